// File: rtl/i2s_rx_framer.sv
// i2s_rx_framer
// Deserialises a stereo I2S stream into 28-bit framed words
// {channel, seq, sample} and presents them on a valid/ready stream
// through a 2-entry output buffer. Words arriving while the buffer is
// full (and not popping) are dropped and flagged on the sticky overrun.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   enable       capture enable; low forces the capture FSM to IDLE and clears overrun
//   bclk         I2S bit clock (asynchronous, synchronised here)
//   lrclk        I2S word select, 0 = left, 1 = right (synchronised here)
//   sdata        I2S serial data, MSB first (synchronised here)
//   source_valid output buffer non-empty
//   source_data  head of the output buffer
//   source_ready consumer accepts a word this cycle
//   overrun      sticky flag: a completed word was dropped
module i2s_rx_framer #(
    parameter int SAMPLE_BITS = 24,
    parameter int SEQ_BITS    = 3,
    parameter int DATA_SIZE   = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 bclk,
    input  logic                 lrclk,
    input  logic                 sdata,
    output logic                 source_valid,
    output logic [DATA_SIZE-1:0] source_data,
    input  logic                 source_ready,
    output logic                 overrun
);

    localparam int CW = $clog2(SAMPLE_BITS + 1);

    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;

    state_t state, state_n;

    logic                   bclk_s1, bclk_s2, bclk_prev;
    logic                   lr_s1, lr_s2;
    logic                   sd_s1, sd_s2;
    logic                   lr_last;
    logic                   primed;
    logic                   chan;
    logic [CW-1:0]          bit_cnt;
    // The LSB is never stored: it goes straight into the pushed word.
    logic [SAMPLE_BITS-2:0] sample;
    logic [SEQ_BITS-1:0]    seq;
    logic                   push_pend;
    logic [DATA_SIZE-1:0]   push_word;
    logic [DATA_SIZE-1:0]   buf0, buf1;
    logic [1:0]             count;
    logic [1:0]             count_after;

    logic rise, lr_change, do_shift, do_push, pop, accept;

    assign rise = bclk_s2 & ~bclk_prev;
    // primed suppresses a false change on the first bclk rise after reset,
    // so capture only starts at a real word boundary.
    assign lr_change = rise & primed & (lr_s2 != lr_last);

    assign source_valid = (count != 2'd0);
    assign source_data  = buf0;
    assign pop          = source_valid & source_ready;
    assign accept       = push_pend & ((count != 2'd2) | pop);
    assign count_after  = count - {1'b0, pop};

    always_comb begin
        state_n  = state;
        do_shift = 1'b0;
        do_push  = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:  if (lr_change) state_n = SKIP;
                // Entered on the rise that carried the previous word's LSB
                // (the one-bit delay slot); the MSB arrives on the next rise.
                SKIP:  state_n = SHIFT;
                SHIFT: begin
                    if (lr_change) begin
                        state_n = SKIP;
                    end else if (rise) begin
                        do_shift = 1'b1;
                        if (bit_cnt == CW'(SAMPLE_BITS - 1)) begin
                            do_push = 1'b1;
                            state_n = WAIT;
                        end
                    end
                end
                WAIT:  if (lr_change) state_n = SKIP;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bclk_s1   <= 1'b0;
            bclk_s2   <= 1'b0;
            bclk_prev <= 1'b0;
            lr_s1     <= 1'b0;
            lr_s2     <= 1'b0;
            sd_s1     <= 1'b0;
            sd_s2     <= 1'b0;
            lr_last   <= 1'b0;
            primed    <= 1'b0;
            chan      <= 1'b0;
            bit_cnt   <= '0;
            sample    <= '0;
            seq       <= '0;
            push_pend <= 1'b0;
            push_word <= '0;
            buf0      <= '0;
            buf1      <= '0;
            count     <= 2'd0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            bclk_s1   <= bclk;
            bclk_s2   <= bclk_s1;
            bclk_prev <= bclk_s2;
            lr_s1     <= lrclk;
            lr_s2     <= lr_s1;
            sd_s1     <= sdata;
            sd_s2     <= sd_s1;

            if (rise) begin
                lr_last <= lr_s2;
                primed  <= 1'b1;
            end

            if (lr_change) begin
                chan    <= lr_s2;
                bit_cnt <= '0;
            end else if (do_shift) begin
                sample  <= (SAMPLE_BITS-1)'({sample, sd_s2});
                bit_cnt <= bit_cnt + CW'(1);
            end

            // Word is staged one cycle, then written into the buffer.
            push_pend <= do_push;
            if (do_push) begin
                push_word <= {chan, seq, sample, sd_s2};
                if (chan) seq <= seq + 1'b1;
            end

            // Pop shifts buf1 forward; a simultaneous push lands behind
            // whatever remains, so the later assignment to buf0 wins when
            // the buffer would otherwise be empty.
            if (pop) buf0 <= buf1;
            if (accept) begin
                if (count_after == 2'd0) buf0 <= push_word;
                else                     buf1 <= push_word;
            end
            count <= count_after + {1'b0, accept};

            if (!enable)                   overrun <= 1'b0;
            else if (push_pend && !accept) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_rx_framer.sv
// tb_i2s_rx_framer
// Self-checking bench for i2s_rx_framer. Drives I2S frames with
// bclk = clk/16 and 32-bit channel slots; expected words are queued
// as each slot is driven and compared as the DUT pops them.
module tb_i2s_rx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        source_valid;
    logic [27:0] source_data;
    logic        source_ready;
    logic        overrun;

    int          total = 0;
    int          bad   = 0;
    logic [27:0] q[$];
    logic [27:0] mon_exp;
    logic [2:0]  mseq;
    int          held;

    i2s_rx_framer #(.SAMPLE_BITS(24), .SEQ_BITS(3), .DATA_SIZE(28)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .source_valid (source_valid),
        .source_data  (source_data),
        .source_ready (source_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Output monitor: a pop happens on the next posedge when valid && ready.
    always begin
        @(negedge clk);
        #2;
        if (!rst && source_valid && source_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word got=%h expected=none", source_data);
            end else begin
                mon_exp = q.pop_front();
                if (source_data !== mon_exp) begin
                    bad++;
                    $display("FAIL word got=%h expected=%h", source_data, mon_exp);
                end
            end
        end
    end

    task automatic bit_period(input logic lr, input logic d, input bit hook);
        @(negedge clk);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        repeat (7) @(negedge clk);
        bclk = 1'b1;
        if (hook) begin
            // Ready rises so the pop lands on the same clk as the buffer write.
            repeat (3) @(negedge clk);
            source_ready = 1'b1;
            held = 0;
            repeat (4) @(negedge clk);
        end else begin
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic send_slot(input logic ch, input logic [23:0] data, input int nbits, input bit hook);
        logic [27:0] e;
        if (nbits == 24) begin
            e = {ch, mseq, data};
            if (!source_ready && !hook && held >= 2) begin
                // buffer full with no pop: the DUT drops this word
            end else begin
                q.push_back(e);
                if (!source_ready && !hook) held++;
            end
            if (ch) mseq = mseq + 3'd1;
        end
        bit_period(ch, 1'($urandom), 1'b0);
        for (int i = 0; i < nbits; i++)
            bit_period(ch, data[23-i], hook && (i == nbits - 1));
        if (nbits == 24)
            for (int i = 0; i < 7; i++) bit_period(ch, 1'($urandom), 1'b0);
    endtask

    task automatic preamble();
        for (int i = 0; i < 3; i++) bit_period(1'b1, 1'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bclk         = 1'b0;
        source_ready = 1'b1;
        enable       = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        q.delete();
        mseq = 3'd0;
        held = 0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #2;
        total++; if (source_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b expected=0", source_valid); end
        total++; if (source_data !== 28'h0) begin bad++; $display("FAIL reset_data got=%h expected=0", source_data); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b expected=0", overrun); end
    endtask

    task automatic test_single_frame();
        do_reset();
        preamble();
        send_slot(1'b0, 24'h123456, 24, 1'b0);
        send_slot(1'b1, 24'hABCDEF, 24, 1'b0);
        wait_drain();
        total++; if (q.size() != 0) begin bad++; $display("FAIL frame_drain got=%0d expected=0", q.size()); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL frame_overrun got=%b expected=0", overrun); end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        preamble();
        for (int f = 0; f < 9; f++) begin
            send_slot(1'b0, (f == 8) ? 24'h000001 : 24'($urandom), 24, 1'b0);
            send_slot(1'b1, 24'($urandom), 24, 1'b0);
        end
        wait_drain();
        total++; if (q.size() != 0) begin bad++; $display("FAIL wrap_drain got=%0d expected=0", q.size()); end
    endtask

    task automatic test_overrun();
        do_reset();
        preamble();
        source_ready = 1'b0;
        send_slot(1'b0, 24'h111111, 24, 1'b0);
        send_slot(1'b1, 24'h222222, 24, 1'b0);
        send_slot(1'b0, 24'h333333, 24, 1'b0);
        #2;
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b expected=1", overrun); end
        total++; if (q.size() != 2) begin bad++; $display("FAIL ovr_queue got=%0d expected=2", q.size()); end
        @(negedge clk);
        source_ready = 1'b1;
        held = 0;
        wait_drain();
        total++; if (q.size() != 0) begin bad++; $display("FAIL ovr_drain got=%0d expected=0", q.size()); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b expected=1", overrun); end
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        #2;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b expected=0", overrun); end
        enable = 1'b1;
        send_slot(1'b1, 24'h444444, 24, 1'b0);
        send_slot(1'b0, 24'h555555, 24, 1'b0);
        send_slot(1'b1, 24'h666666, 24, 1'b0);
        wait_drain();
        total++; if (q.size() != 0) begin bad++; $display("FAIL ovr_tail got=%0d expected=0", q.size()); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_after got=%b expected=0", overrun); end
    endtask

    task automatic test_short_word();
        do_reset();
        preamble();
        send_slot(1'b0, 24'hFFFFFF, 10, 1'b0);
        send_slot(1'b1, 24'h7FFFFF, 24, 1'b0);
        send_slot(1'b0, 24'h00ABCD, 24, 1'b0);
        wait_drain();
        total++; if (q.size() != 0) begin bad++; $display("FAIL short_drain got=%0d expected=0", q.size()); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL short_overrun got=%b expected=0", overrun); end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        preamble();
        source_ready = 1'b0;
        send_slot(1'b0, 24'h0F0F0F, 24, 1'b0);
        send_slot(1'b1, 24'hFFFFFF, 5, 1'b0);
        #2;
        total++; if (source_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b expected=1", source_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (source_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b expected=0", source_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun got=%b expected=0", overrun); end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        mseq = 3'd0;
        held = 0;
        source_ready = 1'b1;
        for (int i = 0; i < 4; i++) bit_period(1'b1, 1'($urandom), 1'b0);
        send_slot(1'b0, 24'h5A5A5A, 24, 1'b0);
        send_slot(1'b1, 24'hA5A5A5, 24, 1'b0);
        wait_drain();
        total++; if (q.size() != 0) begin bad++; $display("FAIL rstmid_drain got=%0d expected=0", q.size()); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        preamble();
        source_ready = 1'b0;
        send_slot(1'b0, 24'hC00001, 24, 1'b0);
        send_slot(1'b1, 24'hC00002, 24, 1'b0);
        #2;
        total++; if (source_valid !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b expected=1", source_valid); end
        send_slot(1'b0, 24'hC00003, 24, 1'b1);
        send_slot(1'b1, 24'hC00004, 24, 1'b0);
        wait_drain();
        total++; if (q.size() != 0) begin bad++; $display("FAIL b2b_drain got=%0d expected=0", q.size()); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b expected=0", overrun); end
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b1;
        bclk         = 1'b0;
        lrclk        = 1'b0;
        sdata        = 1'b0;
        source_ready = 1'b1;
        mseq         = 3'd0;
        held         = 0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_frame();
        test_seq_wrap();
        test_overrun();
        test_short_word();
        test_reset_mid_word();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
